// File: rtl/lcd_msg_scheduler_pkg.sv
// lcd_msg_scheduler_pkg: FSM states, message IDs shared with the LCD writer, and sizing helpers.
package lcd_msg_scheduler_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_HOLD,
    S_RELEASE
  } state_e;
  localparam logic [2:0] MSG_BLANK   = 3'd0;
  localparam logic [2:0] MSG_SUCCESS = 3'd1;
  localparam logic [2:0] MSG_FAIL    = 3'd2;
  localparam logic [2:0] MSG_SCORE   = 3'd3;
  localparam logic [2:0] MSG_LEVEL   = 3'd4;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction
endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// lcd_msg_scheduler_if: requester bus plus LCD writer handshake seen by the scheduler.
interface lcd_msg_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int MSG_W = 3
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*MSG_W-1:0] req_msg;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic                   busy;
  logic                   wr_start;
  logic [MSG_W-1:0]       wr_msg;
  logic                   wr_busy;
  logic                   wr_done;
  modport master (
    input  req, req_msg, wr_busy, wr_done,
    output grant, ack, err, busy, wr_start, wr_msg
  );
  modport slave (
    output req, req_msg, wr_busy, wr_done,
    input  grant, ack, err, busy, wr_start, wr_msg
  );
endinterface

// File: rtl/lcd_msg_scheduler_rr_arbiter.sv
// lcd_msg_scheduler_rr_arbiter: combinational round-robin pick, first set request at or above ptr_i.
module lcd_msg_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // scan from the far end so the closest request to ptr_i is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
    end
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: round-robin owner of the LCD writer with start pulse, hold time and watchdog.
module lcd_msg_scheduler
  import lcd_msg_scheduler_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MSG_W    = 3,
  parameter int HOLD_CYC = 2000000,
  parameter int TIMEOUT  = 100000
) (
  input logic                  clk_i,
  input logic                  resetn_i,
  lcd_msg_scheduler_if.master  bus
);
  localparam int IW = idx_w(N_REQ);
  localparam int CW = cnt_w(HOLD_CYC, TIMEOUT);
  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     rr_q, win_q, rr_d;
  logic [N_REQ-1:0]  grant_q, ack_q;
  logic              err_q, busy_q, start_q;
  logic [MSG_W-1:0]  msg_q;
  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [MSG_W-1:0]  arb_msg;
  lcd_msg_scheduler_rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req_i (bus.req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );
  assign arb_msg = bus.req_msg[arb_idx*MSG_W +: MSG_W];
  assign rr_d    = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      msg_q   <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (arb_any) begin
          grant_q <= arb_gnt;
          win_q   <= arb_idx;
          msg_q   <= arb_msg;
          busy_q  <= 1'b1;
          state_q <= S_START;
        end
        S_START: if (!bus.wr_busy) begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          cnt_q <= cnt_q + 1'b1;
          // a completion coinciding with the watchdog limit still counts as success
          if (bus.wr_done) begin
            cnt_q   <= '0;
            state_q <= S_HOLD;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_RELEASE;
          end
        end
        S_HOLD: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(HOLD_CYC - 1)) state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          ack_q   <= grant_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
          rr_q    <= rr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.wr_start = start_q;
  assign bus.wr_msg   = msg_q;
endmodule
